// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: after init, grants refresh, write or read one at a time
// and muxes the granted requester's command bus onto the SDRAM pins.
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        arb_clk,
    input  logic        arb_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_bank,
    input  logic [12:0] init_addr,
    input  logic        ar_req,
    input  logic        ar_end,
    input  logic [3:0]  ar_cmd,
    input  logic [1:0]  ar_bank,
    input  logic [12:0] ar_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [12:0] wr_addr,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [12:0] rd_addr,
    output logic        ar_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_bank,
    output logic [12:0] sdram_addr
);

    typedef enum logic [2:0] {
        StInit,
        StArbit,
        StAref,
        StWrite,
        StRead
    } state_e;

    state_e state_q, state_d;
    logic   last_wr_q, last_wr_d;
    // Refresh request seen during a write/read; served first on the return to ARBIT.
    logic   ar_pend_q, ar_pend_d;

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q   <= StInit;
            last_wr_q <= 1'b0;
            ar_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            ar_pend_q <= ar_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        ar_pend_d = ar_pend_q;
        unique case (state_q)
            StInit: begin
                if (init_end) state_d = StArbit;
            end
            StArbit: begin
                if (ar_req || ar_pend_q) begin
                    state_d   = StAref;
                    ar_pend_d = 1'b0;
                end else if (wr_req && (!rd_req || !last_wr_q)) begin
                    state_d   = StWrite;
                    last_wr_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = StRead;
                    last_wr_d = 1'b0;
                end
            end
            StAref: begin
                if (ar_end) state_d = StArbit;
            end
            StWrite: begin
                if (ar_req) ar_pend_d = 1'b1;
                if (wr_end) state_d = StArbit;
            end
            StRead: begin
                if (ar_req) ar_pend_d = 1'b1;
                if (rd_end) state_d = StArbit;
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        ar_en      = (state_q == StAref);
        wr_en      = (state_q == StWrite);
        rd_en      = (state_q == StRead);
        sdram_cmd  = CMD_NOP;
        sdram_bank = 2'b00;
        sdram_addr = 13'h0000;
        unique case (state_q)
            StInit: begin
                sdram_cmd  = init_cmd;
                sdram_bank = init_bank;
                sdram_addr = init_addr;
            end
            StAref: begin
                sdram_cmd  = ar_cmd;
                sdram_bank = ar_bank;
                sdram_addr = ar_addr;
            end
            StWrite: begin
                sdram_cmd  = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            StRead: begin
                sdram_cmd  = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: hand-written vector table, reset corner sequences and
// randomized traffic checked against a transaction-level model.
module tb_sdram_arbit;

    logic        arb_clk = 1'b0;
    logic        arb_rst_n;
    logic        init_end;
    logic [3:0]  init_cmd, ar_cmd, wr_cmd, rd_cmd;
    logic [1:0]  init_bank, ar_bank, wr_bank, rd_bank;
    logic [12:0] init_addr, ar_addr, wr_addr, rd_addr;
    logic        ar_req, ar_end, wr_req, wr_end, rd_req, rd_end;
    logic        ar_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank;
    logic [12:0] sdram_addr;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_arbit #(.CMD_NOP(4'b0111)) dut (
        .arb_clk(arb_clk), .arb_rst_n(arb_rst_n), .init_end(init_end),
        .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .ar_req(ar_req), .ar_end(ar_end),
        .ar_cmd(ar_cmd), .ar_bank(ar_bank), .ar_addr(ar_addr),
        .wr_req(wr_req), .wr_end(wr_end),
        .wr_cmd(wr_cmd), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_end(rd_end),
        .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .ar_en(ar_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr)
    );

    always #5 arb_clk = ~arb_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which operation currently owns the bus (init/idle/refresh/write/read).
    string m_op;
    bit    m_last_write;
    bit    m_refresh_owed;

    task automatic model_reset();
        m_op           = "init";
        m_last_write   = 1'b0;
        m_refresh_owed = 1'b0;
    endtask

    task automatic model_clock();
        string nxt;
        nxt = m_op;
        if (m_op == "init") begin
            if (init_end) nxt = "idle";
        end else if (m_op == "idle") begin
            if (ar_req || m_refresh_owed) begin
                nxt = "refresh";
                m_refresh_owed = 1'b0;
            end else if (wr_req && rd_req) begin
                nxt = m_last_write ? "read" : "write";
            end else if (wr_req) begin
                nxt = "write";
            end else if (rd_req) begin
                nxt = "read";
            end
            if (nxt == "write") m_last_write = 1'b1;
            if (nxt == "read")  m_last_write = 1'b0;
        end else if (m_op == "refresh") begin
            if (ar_end) nxt = "idle";
        end else begin
            if (ar_req) m_refresh_owed = 1'b1;
            if (m_op == "write" && wr_end) nxt = "idle";
            if (m_op == "read" && rd_end)  nxt = "idle";
        end
        m_op = nxt;
    endtask

    task automatic check_model(input string tag);
        logic [18:0] bus;
        bus = {4'b0111, 2'b00, 13'h0000};
        if (m_op == "init")    bus = {init_cmd, init_bank, init_addr};
        if (m_op == "refresh") bus = {ar_cmd, ar_bank, ar_addr};
        if (m_op == "write")   bus = {wr_cmd, wr_bank, wr_addr};
        if (m_op == "read")    bus = {rd_cmd, rd_bank, rd_addr};
        chk({tag, "_en"}, {29'd0, ar_en, wr_en, rd_en},
            {29'd0, m_op == "refresh", m_op == "write", m_op == "read"});
        chk({tag, "_cmd"},  {28'd0, sdram_cmd},  {28'd0, bus[18:15]});
        chk({tag, "_bank"}, {30'd0, sdram_bank}, {30'd0, bus[14:13]});
        chk({tag, "_addr"}, {19'd0, sdram_addr}, {19'd0, bus[12:0]});
    endtask

    typedef struct {
        logic       ie, ar, wr, rd, ae, we, re;
        logic [2:0] en;   // {ar_en, wr_en, rd_en} after the edge
        logic [3:0] cmd;
    } vec_t;

    vec_t tbl[18];

    task automatic set_reqs(input logic ar, input logic wr, input logic rd);
        ar_req = ar; wr_req = wr; rd_req = rd;
        ar_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    endtask

    initial begin
        // Distinct command tags per source: init 1, refresh 2, write 4, read 5, NOP 7.
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'h1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 4'h7};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 4'h2};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 4'h2};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'h7};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'h4};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'h4};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 4'h7};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 4'h5};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 4'h7};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'h4};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 4'h4};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 4'h7};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 4'h2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 4'h7};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 4'h5};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 4'h7};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 4'h4};

        init_cmd = 4'h1; ar_cmd = 4'h2; wr_cmd = 4'h4; rd_cmd = 4'h5;
        init_bank = 2'd1; ar_bank = 2'd2; wr_bank = 2'd3; rd_bank = 2'd1;
        init_addr = 13'h0111; ar_addr = 13'h0222; wr_addr = 13'h0333; rd_addr = 13'h0444;
        init_end = 1'b0;
        set_reqs(1'b0, 1'b0, 1'b0);
        arb_rst_n = 1'b0;
        #1;
        chk("reset_en", {29'd0, ar_en, wr_en, rd_en}, 32'd0);
        chk("reset_cmd", {28'd0, sdram_cmd}, 32'h1);
        @(negedge arb_clk);
        arb_rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge arb_clk);
            init_end = tbl[i].ie;
            ar_req = tbl[i].ar; wr_req = tbl[i].wr; rd_req = tbl[i].rd;
            ar_end = tbl[i].ae; wr_end = tbl[i].we; rd_end = tbl[i].re;
            @(posedge arb_clk);
            #1;
            chk($sformatf("tbl%0d_en", i), {29'd0, ar_en, wr_en, rd_en}, {29'd0, tbl[i].en});
            chk($sformatf("tbl%0d_cmd", i), {28'd0, sdram_cmd}, {28'd0, tbl[i].cmd});
        end

        // Finish the write, enter a read, then reset asynchronously mid-read.
        @(negedge arb_clk);
        set_reqs(1'b0, 1'b0, 1'b1);
        wr_end = 1'b1;
        @(posedge arb_clk);
        @(negedge arb_clk);
        set_reqs(1'b0, 1'b0, 1'b1);
        @(posedge arb_clk);
        #1;
        chk("mid_read_en", {31'd0, rd_en}, 32'd1);
        #2;
        arb_rst_n = 1'b0;
        #1;
        chk("async_rst_rd_en", {29'd0, ar_en, wr_en, rd_en}, 32'd0);
        chk("async_rst_cmd", {28'd0, sdram_cmd}, 32'h1);

        // Init phase: bus tracks init_* for 20 cycles with init_end low.
        @(negedge arb_clk);
        arb_rst_n = 1'b1;
        set_reqs(1'b0, 1'b0, 1'b0);
        init_end = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge arb_clk);
            init_cmd  = 4'($urandom);
            init_bank = 2'($urandom);
            init_addr = 13'($urandom);
            @(posedge arb_clk);
            #1;
            check_model("init_wait");
        end
        @(negedge arb_clk);
        init_end = 1'b1;
        model_clock();
        @(posedge arb_clk);
        #1;
        check_model("init_done");
        chk("init_done_nop", {28'd0, sdram_cmd}, 32'h7);

        // Randomized traffic against the model, with occasional async resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge arb_clk);
            arb_rst_n = ($urandom_range(0, 299) != 0);
            init_end  = ($urandom_range(0, 9) != 0);
            ar_req = ($urandom_range(0, 7) == 0);
            wr_req = $urandom_range(0, 1) == 1;
            rd_req = $urandom_range(0, 1) == 1;
            ar_end = ($urandom_range(0, 3) == 0);
            wr_end = ($urandom_range(0, 3) == 0);
            rd_end = ($urandom_range(0, 3) == 0);
            init_cmd = 4'($urandom); ar_cmd = 4'($urandom);
            wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
            init_bank = 2'($urandom); ar_bank = 2'($urandom);
            wr_bank = 2'($urandom); rd_bank = 2'($urandom);
            init_addr = 13'($urandom); ar_addr = 13'($urandom);
            wr_addr = 13'($urandom); rd_addr = 13'($urandom);
            if (!arb_rst_n) model_reset();
            else model_clock();
            @(posedge arb_clk);
            #1;
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
